// File: rtl/dma_burst_sched.sv
// rtl/dma_burst_sched.sv - splits one DMA descriptor into AXI-legal burst requests
// Define DMA_UNALIGNED_EN to enable head/tail partial beats with byte strobes.
module dma_burst_sched #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BEATS   = 256,
  parameter int BYTES_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [BYTES_WIDTH-1:0]  num_bytes_i,
  input  logic                    mode_i,
  input  logic                    abort_i,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [ADDR_WIDTH-1:0]   req_addr_o,
  output logic [7:0]              req_alen_o,
  output logic [2:0]              req_size_o,
  output logic                    req_mode_o,
  output logic [DATA_WIDTH/8-1:0] req_strb_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LB     = $clog2(STRB_W);
  localparam logic [BYTES_WIDTH-1:0] BEAT_BYTES = BYTES_WIDTH'(STRB_W);
  localparam logic [BYTES_WIDTH-1:0] FIXED_CAP  = BYTES_WIDTH'(16);
  localparam logic [BYTES_WIDTH-1:0] INCR_CAP   = BYTES_WIDTH'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, CALC, REQ, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BYTES_WIDTH-1:0] rem_q, rem_d;
  logic [BYTES_WIDTH-1:0] cons_q, cons_d;
  logic                   mode_q, mode_d;
  logic                   abort_q, abort_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [7:0]             req_alen_q, req_alen_d;
  logic [STRB_W-1:0]      req_strb_q, req_strb_d;

  logic [12:0]            room_4k;
  logic [BYTES_WIDTH-1:0] beats;
  logic [ADDR_WIDTH-1:0]  burst_addr;
  logic [7:0]             burst_alen;
  logic [STRB_W-1:0]      burst_strb;
  logic [BYTES_WIDTH-1:0] burst_cons;
`ifdef DMA_UNALIGNED_EN
  logic [LB-1:0]          off;
  logic [BYTES_WIDTH-1:0] head_room;
  logic [STRB_W-1:0]      low_mask;
`endif

  // Next burst from the current address/remaining count; body first, head/tail overrides.
  always_comb begin
    room_4k = 13'h1000 - {1'b0, addr_q[11:0]};
    beats   = rem_q >> LB;
    if (mode_q) begin
      if (beats > FIXED_CAP) beats = FIXED_CAP;
    end else begin
      if (beats > INCR_CAP) beats = INCR_CAP;
      if (beats > BYTES_WIDTH'(room_4k >> LB)) beats = BYTES_WIDTH'(room_4k >> LB);
    end
    burst_addr = {addr_q[ADDR_WIDTH-1:LB], {LB{1'b0}}};
    burst_alen = 8'(beats - BYTES_WIDTH'(1));
    burst_strb = {STRB_W{1'b1}};
    burst_cons = beats << LB;
`ifdef DMA_UNALIGNED_EN
    off       = addr_q[LB-1:0];
    head_room = BEAT_BYTES - BYTES_WIDTH'(off);
    low_mask  = ~({STRB_W{1'b1}} << rem_q[LB-1:0]);
    if ((off != '0) || (rem_q < BEAT_BYTES)) begin
      burst_alen = 8'd0;
      if (rem_q >= head_room) begin
        burst_strb = {STRB_W{1'b1}} << off;
        burst_cons = head_room;
      end else begin
        burst_strb = low_mask << off;
        burst_cons = rem_q;
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    cons_d     = cons_q;
    mode_d     = mode_q;
    abort_d    = abort_q;
    req_addr_d = req_addr_q;
    req_alen_d = req_alen_q;
    req_strb_d = req_strb_q;
    if ((state_q != IDLE) && abort_i) abort_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef DMA_UNALIGNED_EN
          addr_d = addr_i;
          rem_d  = num_bytes_i;
`else
          addr_d = addr_i & ~ADDR_WIDTH'(STRB_W - 1);
          rem_d  = num_bytes_i & ~BYTES_WIDTH'(STRB_W - 1);
`endif
          mode_d  = mode_i;
          abort_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (abort_q || (rem_q == '0)) begin
          state_d = DONE;
        end else begin
          req_addr_d = burst_addr;
          req_alen_d = burst_alen;
          req_strb_d = burst_strb;
          cons_d     = burst_cons;
          state_d    = REQ;
        end
      end
      REQ: begin
        // The request stays up until accepted; a pending abort only acts afterwards.
        if (req_ready_i) begin
          rem_d = (rem_q > cons_q) ? (rem_q - cons_q) : '0;
          if (!mode_q) addr_d = addr_q + ADDR_WIDTH'(cons_q);
          state_d = ((rem_d == '0) || abort_q) ? DONE : CALC;
        end
      end
      DONE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      cons_q     <= '0;
      mode_q     <= 1'b0;
      abort_q    <= 1'b0;
      req_addr_q <= '0;
      req_alen_q <= '0;
      req_strb_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      cons_q     <= cons_d;
      mode_q     <= mode_d;
      abort_q    <= abort_d;
      req_addr_q <= req_addr_d;
      req_alen_q <= req_alen_d;
      req_strb_q <= req_strb_d;
    end
  end

  assign req_valid_o = (state_q == REQ);
  assign req_addr_o  = req_addr_q;
  assign req_alen_o  = req_alen_q;
  assign req_size_o  = 3'(LB);
  assign req_mode_o  = mode_q;
  assign req_strb_o  = req_strb_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign aborted_o   = (state_q == DONE) && abort_q;

endmodule
